// File: rtl/commit_monitor_pkg.sv
// ---------------------------------------------------------------------------
// commit_monitor_pkg
// Shared types and helpers for the commit progress monitor:
//   tracker_state_e : per-core stall tracker states (RUN / STUCK)
//   report_state_e  : report streaming states (IDLE / SEND)
//   POPCOUNT_W      : widest lane vector popcount() accepts (COMMIT_WIDTH <= 64)
//   popcount()      : number of set bits in a zero-extended lane vector
// The report payload struct depends on the top-level widths, so it is declared
// as a parameterised typedef inside commit_progress_monitor.
// ---------------------------------------------------------------------------
package commit_monitor_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STUCK = 1'b1
    } tracker_state_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } report_state_e;

    localparam int unsigned POPCOUNT_W = 64;

    // Count set bits; callers zero-extend narrower lane vectors to POPCOUNT_W.
    function automatic logic [6:0] popcount(input logic [POPCOUNT_W-1:0] bits);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < POPCOUNT_W; i++) begin
            cnt = cnt + {6'd0, bits[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/commit_core_tracker.sv
// ---------------------------------------------------------------------------
// commit_core_tracker
// Per-core retirement tracker: lane popcount, wrap-around instruction
// counter, stall timer and the RUN/STUCK FSM.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   lanes          : commit-valid lanes of this core (need not be contiguous)
//   is_walk        : core is walking; its lanes are not counted as commits
//   stuck_clear    : clears the stuck state and the stall timer
//   instr_cnt      : retired instruction count (registered, wraps)
//   stuck          : core is in STUCK (decoded from the state register)
//   stuck_next     : state after the coming edge will be STUCK
//   stuck_enter    : RUN->STUCK transition happens at the coming edge
// ---------------------------------------------------------------------------
module commit_core_tracker
    import commit_monitor_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 6,
    parameter int unsigned CNT_W        = 64,
    parameter int unsigned STUCK_LIMIT  = 2000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [COMMIT_WIDTH-1:0] lanes,
    input  logic                    is_walk,
    input  logic                    stuck_clear,
    output logic [CNT_W-1:0]        instr_cnt,
    output logic                    stuck,
    output logic                    stuck_next,
    output logic                    stuck_enter
);

    localparam int unsigned N_W   = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned TMR_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(STUCK_LIMIT);

    tracker_state_e     state_r;
    tracker_state_e     state_nxt_s;
    logic [TMR_W-1:0]   timer_r;
    logic [TMR_W-1:0]   timer_nxt_s;
    logic [TMR_W-1:0]   timer_inc_s;
    logic [N_W-1:0]     n_commit_s;
    logic               commit_s;
    logic [CNT_W-1:0]   instr_cnt_r;

    // Counted commits this cycle: a walking core retires nothing.
    always_comb begin
        n_commit_s = {N_W{1'b0}};
        if (is_walk) begin
            n_commit_s = {N_W{1'b0}};
        end else begin
            n_commit_s = N_W'(popcount(POPCOUNT_W'(lanes)));
        end
        commit_s    = (n_commit_s != {N_W{1'b0}});
        timer_inc_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
    end

    // Stall timer and RUN/STUCK next state; a clear overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        if (stuck_clear) begin
            state_nxt_s = RUN;
            timer_nxt_s = {TMR_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (commit_s) begin
                        state_nxt_s = RUN;
                        timer_nxt_s = {TMR_W{1'b0}};
                    end else begin
                        timer_nxt_s = timer_inc_s;
                        if (timer_inc_s == LIMIT) begin
                            state_nxt_s = STUCK;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end
                end
                STUCK: begin
                    // Commits do not leave STUCK; timer stays saturated.
                    state_nxt_s = STUCK;
                    timer_nxt_s = timer_r;
                end
                default: begin
                    state_nxt_s = RUN;
                    timer_nxt_s = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    // State register, stall timer and instruction counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= RUN;
            timer_r     <= {TMR_W{1'b0}};
            instr_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            instr_cnt_r <= instr_cnt_r + CNT_W'(n_commit_s);
        end
    end

    // Output decode from the state register and the next-state logic.
    always_comb begin
        stuck       = (state_r == STUCK);
        stuck_next  = (state_nxt_s == STUCK);
        stuck_enter = (state_r == RUN) && (state_nxt_s == STUCK);
    end

    assign instr_cnt = instr_cnt_r;

endmodule

// File: rtl/commit_progress_monitor.sv
// ---------------------------------------------------------------------------
// commit_progress_monitor
// Tracks retirement progress of NUM_CORES cores, flags stalled cores and
// streams periodic per-core progress reports over a valid/ready port.
// Ports:
//   clock, reset        : clock and synchronous active-high reset
//   commit_valid        : lane j of core i at bit i*COMMIT_WIDTH+j
//   commit_is_walk      : per-core walk indication (lanes not counted)
//   stuck_clear         : clears all stuck flags and stall timers
//   instr_cnt           : per-core retired count, core i at slice i
//   cycle_cnt           : cycles since reset (wraps)
//   stuck / stuck_any   : sticky per-core stuck flags and their OR
//   stuck_first         : index of the first core that went stuck
//   report_valid/ready  : report stream handshake
//   report_core/cycle/instr : report payload
//   report_drop_cnt     : snapshots skipped while a stream was in flight
// ---------------------------------------------------------------------------
module commit_progress_monitor
    import commit_monitor_pkg::*;
#(
    parameter int unsigned NUM_CORES       = 2,
    parameter int unsigned COMMIT_WIDTH    = 6,
    parameter int unsigned CNT_W           = 64,
    parameter int unsigned STUCK_LIMIT     = 2000,
    parameter int unsigned REPORT_INTERVAL = 10000,
    parameter int unsigned IDX_W           = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [NUM_CORES*COMMIT_WIDTH-1:0] commit_valid,
    input  logic [NUM_CORES-1:0]              commit_is_walk,
    input  logic                              stuck_clear,
    output logic [NUM_CORES*CNT_W-1:0]        instr_cnt,
    output logic [CNT_W-1:0]                  cycle_cnt,
    output logic [NUM_CORES-1:0]              stuck,
    output logic                              stuck_any,
    output logic [IDX_W-1:0]                  stuck_first,
    output logic                              report_valid,
    input  logic                              report_ready,
    output logic [IDX_W-1:0]                  report_core,
    output logic [CNT_W-1:0]                  report_cycle,
    output logic [CNT_W-1:0]                  report_instr,
    output logic [15:0]                       report_drop_cnt
);

    typedef struct packed {
        logic [IDX_W-1:0] core;
        logic [CNT_W-1:0] cycle;
        logic [CNT_W-1:0] instr;
    } report_payload_t;

    localparam int unsigned IV_W = $clog2(REPORT_INTERVAL);
    localparam logic [IV_W-1:0]  IV_RELOAD = IV_W'(REPORT_INTERVAL - 1);
    localparam logic [IDX_W-1:0] LAST_CORE = IDX_W'(NUM_CORES - 1);

    logic [CNT_W-1:0]     core_instr_s [NUM_CORES];
    logic [NUM_CORES-1:0] stuck_s;
    logic [NUM_CORES-1:0] stuck_next_s;
    logic [NUM_CORES-1:0] stuck_enter_s;

    logic                 stuck_any_r;
    logic [IDX_W-1:0]     stuck_first_r;
    logic [IDX_W-1:0]     stuck_first_nxt_s;
    logic [IDX_W-1:0]     enter_idx_s;
    logic                 enter_found_s;

    logic [CNT_W-1:0]     cycle_cnt_r;
    logic [IV_W-1:0]      iv_cnt_r;
    logic                 trigger_s;

    report_state_e        rep_state_r;
    report_state_e        rep_state_nxt_s;
    logic                 rep_valid_s;
    logic                 accept_s;
    logic                 load_s;
    logic [IDX_W-1:0]     rep_core_r;
    logic [CNT_W-1:0]     snap_cycle_r;
    logic [CNT_W-1:0]     snap_instr_r [NUM_CORES];
    logic [15:0]          drop_cnt_r;
    report_payload_t      payload_s;

    // ---------------------------------------------------------------
    // Per-core trackers
    // ---------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
        commit_core_tracker #(
            .COMMIT_WIDTH (COMMIT_WIDTH),
            .CNT_W        (CNT_W),
            .STUCK_LIMIT  (STUCK_LIMIT)
        ) u_tracker (
            .clock       (clock),
            .reset       (reset),
            .lanes       (commit_valid[gi*COMMIT_WIDTH +: COMMIT_WIDTH]),
            .is_walk     (commit_is_walk[gi]),
            .stuck_clear (stuck_clear),
            .instr_cnt   (core_instr_s[gi]),
            .stuck       (stuck_s[gi]),
            .stuck_next  (stuck_next_s[gi]),
            .stuck_enter (stuck_enter_s[gi])
        );
        assign instr_cnt[gi*CNT_W +: CNT_W] = core_instr_s[gi];
    end

    // ---------------------------------------------------------------
    // First-stuck arbitration
    // ---------------------------------------------------------------

    // Lowest-index core entering STUCK this cycle; latched only when no
    // core is stuck yet, so a later entrant never overwrites the first.
    always_comb begin
        enter_idx_s   = {IDX_W{1'b0}};
        enter_found_s = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!enter_found_s && stuck_enter_s[i]) begin
                enter_idx_s   = IDX_W'(i);
                enter_found_s = 1'b1;
            end else begin
                enter_found_s = enter_found_s;
            end
        end
        if (stuck_clear) begin
            stuck_first_nxt_s = {IDX_W{1'b0}};
        end else if (!stuck_any_r && enter_found_s) begin
            stuck_first_nxt_s = enter_idx_s;
        end else begin
            stuck_first_nxt_s = stuck_first_r;
        end
    end

    // Registered stuck summary and first-stuck index.
    always_ff @(posedge clock) begin
        if (reset) begin
            stuck_any_r   <= 1'b0;
            stuck_first_r <= {IDX_W{1'b0}};
        end else begin
            stuck_any_r   <= |stuck_next_s;
            stuck_first_r <= stuck_first_nxt_s;
        end
    end

    // ---------------------------------------------------------------
    // Cycle counter and report interval timer
    // ---------------------------------------------------------------
    assign trigger_s = (iv_cnt_r == {IV_W{1'b0}});

    // Free-running cycle counter and interval down-counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_cnt_r <= {CNT_W{1'b0}};
            iv_cnt_r    <= IV_RELOAD;
        end else begin
            cycle_cnt_r <= cycle_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (trigger_s) begin
                iv_cnt_r <= IV_RELOAD;
            end else begin
                iv_cnt_r <= iv_cnt_r - {{(IV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ---------------------------------------------------------------
    // Report FSM
    // ---------------------------------------------------------------

    // Report state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_state_r <= IDLE;
        end else begin
            rep_state_r <= rep_state_nxt_s;
        end
    end

    // Report next state: leave SEND once the last core's beat is accepted.
    always_comb begin
        rep_state_nxt_s = rep_state_r;
        case (rep_state_r)
            IDLE: begin
                if (trigger_s) begin
                    rep_state_nxt_s = SEND;
                end else begin
                    rep_state_nxt_s = IDLE;
                end
            end
            SEND: begin
                if (report_ready && (rep_core_r == LAST_CORE)) begin
                    rep_state_nxt_s = IDLE;
                end else begin
                    rep_state_nxt_s = SEND;
                end
            end
            default: begin
                rep_state_nxt_s = IDLE;
            end
        endcase
    end

    // Report output decode and datapath strobes.
    always_comb begin
        rep_valid_s = (rep_state_r == SEND);
        accept_s    = rep_valid_s && report_ready;
        load_s      = (rep_state_r == IDLE) && trigger_s;
    end

    // Snapshot and beat sequencing. The snapshot array is a shift register
    // whose head is always the instruction count of the core being sent.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_core_r   <= {IDX_W{1'b0}};
            snap_cycle_r <= {CNT_W{1'b0}};
            drop_cnt_r   <= 16'd0;
            for (int i = 0; i < NUM_CORES; i++) begin
                snap_instr_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            if (load_s) begin
                rep_core_r   <= {IDX_W{1'b0}};
                snap_cycle_r <= cycle_cnt_r;
                for (int i = 0; i < NUM_CORES; i++) begin
                    snap_instr_r[i] <= core_instr_s[i];
                end
            end else if (accept_s && (rep_core_r != LAST_CORE)) begin
                rep_core_r <= rep_core_r + {{(IDX_W-1){1'b0}}, 1'b1};
                for (int i = 0; i < NUM_CORES - 1; i++) begin
                    snap_instr_r[i] <= snap_instr_r[i+1];
                end
            end else begin
                rep_core_r <= rep_core_r;
            end
            // A trigger during a stream is dropped, not queued.
            if (trigger_s && rep_valid_s && (drop_cnt_r != 16'hFFFF)) begin
                drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    always_comb begin
        payload_s.core  = rep_core_r;
        payload_s.cycle = snap_cycle_r;
        payload_s.instr = snap_instr_r[0];
    end

    assign cycle_cnt       = cycle_cnt_r;
    assign stuck           = stuck_s;
    assign stuck_any       = stuck_any_r;
    assign stuck_first     = stuck_first_r;
    assign report_valid    = rep_valid_s;
    assign report_core     = payload_s.core;
    assign report_cycle    = payload_s.cycle;
    assign report_instr    = payload_s.instr;
    assign report_drop_cnt = drop_cnt_r;

endmodule
